// File: rtl/avr_imem_responder.sv
// avr_imem_responder: program memory with load port and a valid/ready fetch port
// that has one registered read stage feeding a 2-entry response FIFO.
module avr_imem_responder #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter logic [DW-1:0] NOP_WORD = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic [AW-1:0] o_rsp_addr,
  output logic          o_rsp_err,
  output logic [AW:0]   o_prog_len
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW:0]   r_len;
  logic          r_s1_v;
  logic [AW-1:0] r_s1_addr;
  logic [DW-1:0] r_fd [2];
  logic [AW-1:0] r_fa [2];
  logic [1:0]    r_fe;
  logic          r_rp, r_wp;
  logic [1:0]    r_cnt;
  logic [1:0]    w_occ;
  logic          w_pop, w_acc, w_err;
  logic [AW:0]   w_ld1;
  assign w_occ       = r_cnt + {1'b0, r_s1_v};
  assign o_rsp_valid = r_cnt != 2'd0;
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  // a full pipeline may still accept when the head is leaving this cycle
  assign o_req_ready = i_reset && !i_ld_en && (w_occ < 2'd2 || (w_occ == 2'd2 && w_pop));
  assign w_acc       = i_req_valid && o_req_ready;
  assign w_err       = {1'b0, r_s1_addr} >= r_len;
  assign w_ld1       = {1'b0, i_ld_addr} + {{AW{1'b0}}, 1'b1};
  assign o_rsp_data  = r_fd[r_rp];
  assign o_rsp_addr  = r_fa[r_rp];
  assign o_rsp_err   = r_fe[r_rp];
  assign o_prog_len  = r_len;
  always_ff @(posedge i_clk) begin
    if (i_ld_en) r_mem[i_ld_addr] <= i_ld_data;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_len     <= '0;
      r_s1_v    <= 1'b0;
      r_s1_addr <= '0;
      r_fd[0]   <= '0;
      r_fd[1]   <= '0;
      r_fa[0]   <= '0;
      r_fa[1]   <= '0;
      r_fe      <= '0;
      r_rp      <= 1'b0;
      r_wp      <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (i_ld_en && w_ld1 > r_len) r_len <= w_ld1;
      r_s1_v <= w_acc;
      if (w_acc) r_s1_addr <= i_req_addr;
      if (r_s1_v) begin
        r_fd[r_wp] <= w_err ? NOP_WORD : r_mem[r_s1_addr];
        r_fa[r_wp] <= r_s1_addr;
        r_fe[r_wp] <= w_err;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_s1_v} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_avr_imem_responder.sv
// tb_avr_imem_responder: table-driven cycles with a response scoreboard.
module tb_avr_imem_responder;
  localparam int AW = 8, DW = 16;
  logic clk = 0, rst_n = 0, ld_en = 0, rv = 0, rr = 0;
  logic [AW-1:0] la = 0, ra = 0;
  logic [DW-1:0] ldat = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [AW:0] prog_len;
  int checks = 0, errors = 0;
  typedef struct {logic [DW-1:0] d; logic [AW-1:0] a; logic e;} rsp_t;
  typedef struct {logic l; logic [AW-1:0] la; logic [DW-1:0] ld; logic v; logic [AW-1:0] a; logic rr; logic er; logic ev;} vec_t;
  rsp_t sb[$];
  rsp_t h_r;
  logic h_v = 0;
  logic [DW-1:0] m_mem [256];
  logic [AW:0] m_len = 0;
  vec_t tv [31];

  avr_imem_responder #(.AW(AW), .DW(DW), .NOP_WORD(16'h0000)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_ld_en(ld_en), .i_ld_addr(la), .i_ld_data(ldat),
    .i_req_valid(rv), .o_req_ready(req_ready), .i_req_addr(ra),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rr), .o_rsp_data(rsp_data),
    .o_rsp_addr(rsp_addr), .o_rsp_err(rsp_err), .o_prog_len(prog_len));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && dut.r_s1_v && dut.r_cnt == 2'd2 && !(rsp_valid && rr)) begin
      errors++;
      $display("FAIL fifo_overflow: got push into full buffer, required no push");
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", n, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [AW-1:0] lad, input logic [DW-1:0] ld,
                     input logic v, input logic [AW-1:0] a, input logic rdy);
    rsp_t x;
    logic e;
    @(negedge clk);
    rst_n = r; ld_en = l; la = lad; ldat = ld; rv = v; ra = a; rr = rdy;
    #1;
    chk("prog_len", prog_len, m_len);
    if (h_v) begin
      chk("hold_data", rsp_data, h_r.d);
      chk("hold_addr", rsp_addr, h_r.a);
      chk("hold_err", rsp_err, h_r.e);
    end
    h_v = rsp_valid && !rr;
    h_r = '{rsp_data, rsp_addr, rsp_err};
    if (rsp_valid && rr) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got addr %0h data %0h, required no response", rsp_addr, rsp_data);
      end else begin
        x = sb.pop_front();
        chk("rsp_data", rsp_data, x.d);
        chk("rsp_addr", rsp_addr, x.a);
        chk("rsp_err", rsp_err, x.e);
      end
    end
    if (v && req_ready) begin
      e = {1'b0, a} >= m_len;
      sb.push_back('{e ? 16'h0000 : m_mem[a], a, e});
    end
    if (!r) begin
      sb.delete(); m_len = 0; h_v = 0;
    end else if (l) begin
      m_mem[lad] = ld;
      if ({1'b0, lad} + 9'd1 > m_len) m_len = {1'b0, lad} + 9'd1;
    end
  endtask

  initial begin
    tv = '{
      '{1, 0, 16'hE00F, 0, 0, 1, 0, 0}, '{1, 1, 16'h940C, 0, 0, 1, 0, 0},
      '{1, 2, 16'h0000, 0, 0, 1, 0, 0}, '{1, 3, 16'hCFFF, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 0, 1, 1, 0}, '{0, 0, 0, 1, 1, 1, 1, 0},
      '{0, 0, 0, 1, 2, 1, 1, 1}, '{0, 0, 0, 1, 3, 1, 1, 1},
      '{0, 0, 0, 0, 0, 1, 1, 1}, '{0, 0, 0, 0, 0, 1, 1, 1},
      '{0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 1, 0, 0, 1, 0}, '{0, 0, 0, 1, 1, 0, 1, 0},
      '{0, 0, 0, 1, 2, 0, 0, 1}, '{0, 0, 0, 1, 2, 0, 0, 1},
      '{0, 0, 0, 1, 2, 1, 1, 1}, '{0, 0, 0, 1, 3, 1, 1, 1},
      '{0, 0, 0, 0, 0, 1, 1, 1}, '{0, 0, 0, 0, 0, 1, 1, 1},
      '{0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 1, 7, 1, 1, 0}, '{0, 0, 0, 0, 0, 1, 1, 0}, '{0, 0, 0, 0, 0, 1, 1, 1},
      '{1, 5, 16'h1234, 1, 5, 1, 0, 0}, '{0, 0, 0, 1, 5, 1, 1, 0},
      '{0, 0, 0, 0, 0, 1, 1, 0}, '{0, 0, 0, 0, 0, 1, 1, 1},
      '{1, 255, 16'hABCD, 0, 0, 1, 0, 0}, '{0, 0, 0, 1, 255, 1, 1, 0},
      '{0, 0, 0, 0, 0, 1, 1, 0}, '{0, 0, 0, 0, 0, 1, 1, 1}
    };
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    for (int i = 0; i < 31; i++) begin
      cyc(1, tv[i].l, tv[i].la, tv[i].ld, tv[i].v, tv[i].a, tv[i].rr);
      chk($sformatf("req_ready[%0d]", i), req_ready, tv[i].er);
      chk($sformatf("rsp_valid[%0d]", i), rsp_valid, tv[i].ev);
    end
    chk("prog_len_256", prog_len, 256);
    chk("sb_drained", sb.size(), 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    chk("mid_acc0", req_ready, 1);
    cyc(1, 0, 0, 0, 1, 1, 0);
    chk("mid_acc1", req_ready, 1);
    cyc(0, 0, 0, 0, 1, 2, 0);
    chk("mid_rst_ready", req_ready, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_data", rsp_data, 0);
    chk("mid_rsp_addr", rsp_addr, 0);
    chk("mid_rsp_err", rsp_err, 0);
    chk("mid_prog_len", prog_len, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 1);
      chk("post_rst_idle", rsp_valid, 0);
    end
    cyc(1, 1, 1, 16'h940C, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 1);
    chk("retained_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avr_imem_responder.md
Name: avr_imem_responder

Overview:
- Program-memory responder for the AVR core: the fetch-side counterpart to the core's instruction-fetch initiator.
- A load port lets the environment's driver write program words.
- A valid/ready fetch port serves instruction words with registered latency and a 2-entry response buffer, so core back-pressure never drops data.
- Sits between the top-level interface and the core's fetch unit.

Parameters:
- AW, 8, word-address width; memory depth is 2**AW words.
- DW, 16, instruction word width (AVR 16-bit opcode).
- NOP_WORD, 16'h0000, word returned for fetches beyond the loaded program length.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0), sampled on the rising edge of clk.
- ld_en  input  1  load strobe; writes ld_data at ld_addr this cycle.
- ld_addr  input  AW  load word address.
- ld_data  input  DW  load word.
- req_valid  input  1  fetch request valid.
- req_ready  output  1  fetch request accepted when req_valid && req_ready.
- req_addr  input  AW  fetch word address.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response when rsp_valid && rsp_ready.
- rsp_data  output  DW  fetched word.
- rsp_addr  output  AW  address the response belongs to.
- rsp_err  output  1  fetch address was >= prog_len; rsp_data = NOP_WORD.
- prog_len  output  AW+1  loaded program length in words: highest loaded address + 1.

Behaviour:
- Reset (reset==0 at a clock edge):
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, prog_len=0.
  - Buffer and in-flight stage are cleared.
  - Memory contents are not cleared.
- Reset mid-operation: all buffered and in-flight responses are discarded and none are emitted after reset release.
- Load:
  - On ld_en, mem[ld_addr] <= ld_data.
  - prog_len <= max(prog_len, ld_addr+1), computed in AW+1 bits, so ld_addr=2**AW-1 gives prog_len=2**AW with no wrap.
- Load/fetch priority:
  - Load wins. req_ready=0 in any cycle ld_en=1.
  - A request never reads a word being written in the same cycle.
- Fetch pipeline:
  - Stage 0: a request accepted at edge N registers addr into the read stage.
  - Stage 1: at edge N+1 the memory word (or NOP_WORD with err=1 if addr >= prog_len) is pushed into the 2-entry response FIFO.
  - rsp_valid is high after edge N+1: 1-cycle latency with an empty FIFO.
- Flow control:
  - occupancy = FIFO count + (read stage valid ? 1 : 0).
  - req_ready = reset released && !ld_en && (occupancy < 2 || (occupancy==2 && rsp_valid && rsp_ready)).
  - A FIFO pop and push in the same cycle keep count unchanged.
  - The FIFO never overflows; an overflow attempt is a design error (bench asserts).
- Ordering: responses are in request order. rsp_data, rsp_addr and rsp_err are held stable while rsp_valid && !rsp_ready.
- Back-to-back throughput: one response per cycle when rsp_ready is held high.
- prog_len comparison uses the value registered before the request's stage-1 edge.
- Address wrap: none. req_addr is AW bits, and all addresses 0..2**AW-1 are legal.

Test Plan:
- Load words 0..3 = 16'hE00F, 16'h940C, 16'h0000, 16'hCFFF, then fetch addrs 0..3 back-to-back with rsp_ready=1 -> rsp_valid each cycle from 1 cycle after the first accept; data in order; rsp_addr 0..3; rsp_err=0; prog_len=4.
- Same load, fetch 0..3 with rsp_ready=0 -> req_ready drops after 2 accepts; rsp_data held at 16'hE00F. Then raise rsp_ready -> all 4 returned, none lost or duplicated.
- prog_len=4, fetch addr 7 -> rsp_data=16'h0000, rsp_err=1, rsp_addr=7.
- ld_en=1 with req_valid=1 in the same cycle (ld_addr=5, data 16'h1234, req_addr=5) -> req_ready=0 that cycle; the request accepted the next cycle returns 16'h1234.
- Load addr 255 (AW=8) with 16'hABCD -> prog_len=256; fetch 255 -> 16'hABCD, rsp_err=0.
- Two requests in flight, then reset=0 for one cycle -> all outputs zero after that edge; no responses appear after release; memory word 0 still reads 16'hE00F.
